// File: rtl/sample_controller_pkg.sv
// Shared types for the sample-processing sequencer:
// datapath opcodes, register indices and FSM state encoding.
package sample_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_COPY = 3'd1,
      OP_LOAD = 3'd2,
      OP_ADD  = 3'd4,
      OP_SUB  = 3'd5
   } op_t;

   localparam logic [3:0] ACC = 4'd0;
   localparam logic [3:0] OLD = 4'd4;
   localparam logic [3:0] NEW = 4'd5;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_STORE   = 4'd1,
      S_SUB_OLD = 4'd2,
      S_SH3     = 4'd3,
      S_SH2     = 4'd4,
      S_SH1     = 4'd5,
      S_SH0     = 4'd6,
      S_ADD_NEW = 4'd7,
      S_CLR     = 4'd8,
      S_EIDLE   = 4'd9
   } state_t;

endpackage

// File: rtl/sample_controller.sv
// Moore sequencer stepping the register-file datapath through a
// 4-tap running-sum update per sample, with block-end clear.
module sample_controller
   import sample_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       n_reset,
   input  logic       dr,
   input  logic       overflow,
   input  logic       one_k_samples,
   output logic       cnt_up,
   output logic       clear,
   output logic       modwait,
   output logic [2:0] op,
   output logic [3:0] src1,
   output logic [3:0] src2,
   output logic [3:0] dest,
   output logic       err
);

   state_t state;
   state_t state_nxt;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // dr is only looked at while waiting or in STORE
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:    if (dr) state_nxt = S_STORE;
         S_STORE:   state_nxt = dr ? S_SUB_OLD : S_EIDLE;
         S_SUB_OLD: state_nxt = overflow ? S_EIDLE : S_SH3;
         S_SH3:     state_nxt = S_SH2;
         S_SH2:     state_nxt = S_SH1;
         S_SH1:     state_nxt = S_SH0;
         S_SH0:     state_nxt = S_ADD_NEW;
         S_ADD_NEW: begin
            if (overflow)           state_nxt = S_EIDLE;
            else if (one_k_samples) state_nxt = S_CLR;
            else                    state_nxt = S_IDLE;
         end
         S_CLR:     state_nxt = S_IDLE;
         S_EIDLE:   if (dr) state_nxt = S_STORE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      op      = OP_NOP;
      src1    = 4'd0;
      src2    = 4'd0;
      dest    = 4'd0;
      cnt_up  = 1'b0;
      clear   = 1'b0;
      modwait = 1'b0;
      err     = 1'b0;
      unique case (state)
         S_IDLE: ;
         S_STORE: begin
            op      = OP_LOAD;
            dest    = NEW;
            cnt_up  = 1'b1;
            modwait = 1'b1;
         end
         S_SUB_OLD: begin
            op      = OP_SUB;
            src1    = ACC;
            src2    = OLD;
            dest    = ACC;
            modwait = 1'b1;
         end
         S_SH3: begin
            op      = OP_COPY;
            src1    = 4'd3;
            dest    = OLD;
            modwait = 1'b1;
         end
         S_SH2: begin
            op      = OP_COPY;
            src1    = 4'd2;
            dest    = 4'd3;
            modwait = 1'b1;
         end
         S_SH1: begin
            op      = OP_COPY;
            src1    = 4'd1;
            dest    = 4'd2;
            modwait = 1'b1;
         end
         S_SH0: begin
            op      = OP_COPY;
            src1    = NEW;
            dest    = 4'd1;
            modwait = 1'b1;
         end
         S_ADD_NEW: begin
            op      = OP_ADD;
            src1    = ACC;
            src2    = 4'd1;
            dest    = ACC;
            modwait = 1'b1;
         end
         S_CLR: begin
            clear   = 1'b1;
            modwait = 1'b1;
         end
         S_EIDLE: err = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sample_controller.sv
// Directed bench for sample_controller: vector table for single-cycle
// transitions, hand sequences for reset and 1000-sample block end.
module tb_sample_controller;

   logic       clk = 1'b0;
   logic       n_reset;
   logic       dr;
   logic       overflow;
   logic       one_k_in;
   logic       cnt_up;
   logic       clear;
   logic       modwait;
   logic [2:0] op;
   logic [3:0] src1;
   logic [3:0] src2;
   logic [3:0] dest;
   logic       err;

   logic       tb_onek;
   logic       use_model;
   logic [9:0] cnt;
   logic       model_onek;

   int checks = 0;
   int errors = 0;

   sample_controller dut (
      .clk           (clk),
      .n_reset       (n_reset),
      .dr            (dr),
      .overflow      (overflow),
      .one_k_samples (one_k_in),
      .cnt_up        (cnt_up),
      .clear         (clear),
      .modwait       (modwait),
      .op            (op),
      .src1          (src1),
      .src2          (src2),
      .dest          (dest),
      .err           (err)
   );

   always #5 clk = ~clk;

   // saturating 1000-sample counter model
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) cnt <= 10'd0;
      else if (clear) cnt <= 10'd0;
      else if (cnt_up && cnt != 10'd1000) cnt <= cnt + 10'd1;
   end

   assign model_onek = (cnt == 10'd1000);
   assign one_k_in   = use_model ? model_onek : tb_onek;

   typedef struct {
      logic        dr;
      logic        ov;
      logic        onek;
      logic [18:0] exp;
   } vec_t;

   vec_t tv[64];
   int   nv = 0;

   logic [18:0] E_IDLE, E_STORE, E_SUB, E_SH3, E_SH2;
   logic [18:0] E_SH1, E_SH0, E_ADD, E_CLR, E_ERR;

   function automatic logic [18:0] o(input logic [2:0] opc,
                                     input logic [3:0] s1,
                                     input logic [3:0] s2,
                                     input logic [3:0] d,
                                     input logic mw, input logic cu,
                                     input logic cl, input logic er);
      return {opc, s1, s2, d, mw, cu, cl, er};
   endfunction

   function automatic logic [18:0] outs();
      return {op, src1, src2, dest, modwait, cnt_up, clear, err};
   endfunction

   task automatic add(input logic d, input logic v, input logic k,
                      input logic [18:0] e);
      tv[nv] = '{dr: d, ov: v, onek: k, exp: e};
      nv++;
   endtask

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_sample(input bit ov_add, output int mw,
                             output bit clr, output bit clr_after_add);
      bit prev_add;
      mw = 0;
      clr = 0;
      clr_after_add = 0;
      prev_add = 0;
      dr = 1'b1;
      step();
      for (int i = 0; i < 20; i++) begin
         if (!modwait) break;
         mw++;
         if (clear) begin
            clr = 1;
            clr_after_add = prev_add;
         end
         prev_add = (op == 3'd4);
         if (i > 0) dr = 1'b0;
         overflow = ov_add && (op == 3'd4);
         step();
         overflow = 1'b0;
      end
   endtask

   int  mw;
   bit  clr;
   bit  caa;
   int  bad;

   initial begin
      E_IDLE  = '0;
      E_STORE = o(3'd2, 4'd0, 4'd0, 4'd5, 1, 1, 0, 0);
      E_SUB   = o(3'd5, 4'd0, 4'd4, 4'd0, 1, 0, 0, 0);
      E_SH3   = o(3'd1, 4'd3, 4'd0, 4'd4, 1, 0, 0, 0);
      E_SH2   = o(3'd1, 4'd2, 4'd0, 4'd3, 1, 0, 0, 0);
      E_SH1   = o(3'd1, 4'd1, 4'd0, 4'd2, 1, 0, 0, 0);
      E_SH0   = o(3'd1, 4'd5, 4'd0, 4'd1, 1, 0, 0, 0);
      E_ADD   = o(3'd4, 4'd0, 4'd1, 4'd0, 1, 0, 0, 0);
      E_CLR   = o(3'd0, 4'd0, 4'd0, 4'd0, 1, 0, 1, 0);
      E_ERR   = o(3'd0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1);

      // single sample, dr toggles mid-sequence ignored
      add(1, 0, 0, E_STORE); add(1, 0, 0, E_SUB);
      add(0, 0, 0, E_SH3);   add(1, 0, 0, E_SH2);
      add(0, 0, 0, E_SH1);   add(1, 0, 0, E_SH0);
      add(0, 0, 0, E_ADD);   add(0, 0, 0, E_IDLE);
      add(0, 0, 0, E_IDLE);
      // overflow in SUB_OLD, recovery
      add(1, 0, 0, E_STORE); add(1, 0, 0, E_SUB);
      add(0, 1, 0, E_ERR);   add(0, 0, 0, E_ERR);
      add(1, 0, 0, E_STORE); add(1, 0, 0, E_SUB);
      add(0, 0, 0, E_SH3);   add(0, 1, 0, E_SH2);
      add(0, 0, 0, E_SH1);   add(0, 0, 0, E_SH0);
      add(0, 0, 0, E_ADD);
      // overflow beats one_k in ADD_NEW
      add(1, 1, 1, E_ERR);
      // protocol error
      add(1, 0, 0, E_STORE); add(0, 0, 0, E_ERR);
      // block end with CLR, then back-to-back
      add(1, 0, 0, E_STORE); add(1, 0, 0, E_SUB);
      add(0, 0, 1, E_SH3);   add(0, 0, 0, E_SH2);
      add(0, 0, 0, E_SH1);   add(0, 0, 0, E_SH0);
      add(1, 0, 0, E_ADD);   add(1, 0, 1, E_CLR);
      add(1, 0, 0, E_IDLE);  add(1, 0, 0, E_STORE);
      add(1, 0, 0, E_SUB);   add(0, 0, 0, E_SH3);
      add(0, 0, 0, E_SH2);   add(0, 0, 0, E_SH1);
      add(0, 0, 0, E_SH0);   add(0, 0, 0, E_ADD);
      add(1, 0, 0, E_IDLE);  add(1, 0, 0, E_STORE);
      add(0, 0, 0, E_ERR);

      n_reset   = 1'b0;
      dr        = 1'b0;
      overflow  = 1'b0;
      tb_onek   = 1'b0;
      use_model = 1'b0;
      #1;
      check("reset_outs", {13'd0, outs()}, {13'd0, E_IDLE});
      step();
      step();
      n_reset = 1'b1;
      step();
      check("idle_after_reset", {13'd0, outs()}, {13'd0, E_IDLE});

      for (int i = 0; i < nv; i++) begin
         dr       = tv[i].dr;
         overflow = tv[i].ov;
         tb_onek  = tv[i].onek;
         step();
         check($sformatf("vec%0d", i), {13'd0, outs()},
               {13'd0, tv[i].exp});
      end
      dr = 1'b0;
      overflow = 1'b0;
      tb_onek = 1'b0;

      // async reset in SH2
      step();
      step();
      dr = 1'b1;
      step();
      step();
      dr = 1'b0;
      step();
      step();
      check("reach_sh2", {13'd0, outs()}, {13'd0, E_SH2});
      #2;
      n_reset = 1'b0;
      #1;
      check("async_reset", {13'd0, outs()}, {13'd0, E_IDLE});
      step();
      n_reset = 1'b1;
      step();
      step();
      check("idle_hold", {13'd0, outs()}, {13'd0, E_IDLE});

      // 1000-sample block against counter model
      use_model = 1'b1;
      n_reset = 1'b0;
      step();
      n_reset = 1'b1;
      step();
      bad = 0;
      for (int i = 0; i < 999; i++) begin
         run_sample(0, mw, clr, caa);
         if (mw != 7 || clr) bad++;
      end
      check("block_999_clean", bad, 0);
      check("count_999", {22'd0, cnt}, 32'd999);
      run_sample(0, mw, clr, caa);
      check("blk_mw8", mw, 8);
      check("blk_clear", {31'd0, clr}, 32'd1);
      check("blk_clear_after_add", {31'd0, caa}, 32'd1);
      check("blk_count0", {22'd0, cnt}, 32'd0);
      check("blk_onek_low", {31'd0, model_onek}, 32'd0);

      // overflow collides with block end
      bad = 0;
      for (int i = 0; i < 999; i++) begin
         run_sample(0, mw, clr, caa);
         if (mw != 7 || clr) bad++;
      end
      check("block2_999_clean", bad, 0);
      run_sample(1, mw, clr, caa);
      check("ovk_mw7", mw, 7);
      check("ovk_no_clear", {31'd0, clr}, 32'd0);
      check("ovk_err", {31'd0, err}, 32'd1);
      check("ovk_count1000", {22'd0, cnt}, 32'd1000);
      run_sample(0, mw, clr, caa);
      check("next_mw8", mw, 8);
      check("next_clear", {31'd0, clr}, 32'd1);
      check("next_count0", {22'd0, cnt}, 32'd0);
      check("next_err0", {31'd0, err}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sample_controller.md
# sample_controller

Sequencing FSM for the sample-processing unit: it accepts one sample per `dr` (data-ready) assertion and steps the register-file datapath through a 4-tap running-sum update. It pulses `cnt_up` into the 1000-sample counter and consumes that counter's `one_k_samples` flag to issue `clear` at block end. It flags overflow and protocol errors via `err`. It sits between the input interface, the datapath, and the sample counter.

## Interface
Parameters: none.

- `clk` input 1: system clock; all state changes on the rising edge.
- `n_reset` input 1: asynchronous, active-low reset.
- `dr` input 1: data ready; the sample is valid and held by the source while high.
- `overflow` input 1: datapath arithmetic overflow for the current op (combinational from the datapath).
- `one_k_samples` input 1: from the sample counter; high while the count equals 1000.
- `cnt_up` output 1: one-cycle increment pulse to the sample counter.
- `clear` output 1: one-cycle clear to the sample counter.
- `modwait` output 1: busy; high while a sample is being processed.
- `op` output 3: datapath opcode.
- `src1` output 4: datapath source register index.
- `src2` output 4: datapath source register index.
- `dest` output 4: datapath destination register index.
- `err` output 1: error indication.

## Operation
- Moore FSM. Outputs are decoded from the state register only.
- Register map:
  - R0: running sum.
  - R1–R4: sample history, R4 is the oldest.
  - R5: incoming sample.
- States and actions (any field not listed is 0 / NOP):
  - IDLE: modwait=0. On `dr`=1, go to STORE.
  - STORE: op=LOAD, dest=5, cnt_up=1, modwait=1. If `dr`=0, go to EIDLE; else go to SUB_OLD.
  - SUB_OLD: op=SUB, src1=0, src2=4, dest=0. If `overflow`, go to EIDLE; else go to SH3.
  - SH3: op=COPY, src1=3, dest=4. Go to SH2.
  - SH2: op=COPY, src1=2, dest=3. Go to SH1.
  - SH1: op=COPY, src1=1, dest=2. Go to SH0.
  - SH0: op=COPY, src1=5, dest=1. Go to ADD_NEW.
  - ADD_NEW: op=ADD, src1=0, src2=1, dest=0. If `overflow`, go to EIDLE; else if `one_k_samples`, go to CLR; else go to IDLE.
  - CLR: clear=1, modwait=1. Go to IDLE.
  - EIDLE: err=1, modwait=0. On `dr`=1, go to STORE (err drops in STORE).
- Overflow takes priority over `one_k_samples` in ADD_NEW. If both are high, `clear` is not issued; the counter stays at 1000 until the next good completion.
- `dr` is sampled only in IDLE, EIDLE and STORE. `dr` toggling in other states is ignored.
- Opcodes are 3-bit: NOP=3'd0, COPY=3'd1, LOAD=3'd2, ADD=3'd4, SUB=3'd5.

## Timing
- Reset (asynchronous, `n_reset`=0): state goes to IDLE immediately. All outputs are 0: op=NOP, src1/src2/dest=0, modwait/cnt_up/clear/err=0.
- Reset mid-sequence aborts the sequence without any further datapath op.
- Latency from `dr` sampled high in IDLE:
  - modwait rises after 1 cycle.
  - Normal completion: modwait is high for 7 cycles (STORE..ADD_NEW).
  - Block-end completion: modwait is high for 8 cycles (includes CLR).
- `cnt_up` is high exactly one cycle per accepted sample, in STORE, including samples later aborted by overflow.
- Once the 1000th `cnt_up` lands, the counter raises `one_k_samples` before ADD_NEW. `clear` follows in the next cycle.
- Back-to-back samples: if `dr` is high in the IDLE cycle following completion, STORE is entered the next cycle. Minimum sample period is 8 cycles (9 with CLR).
- `dr` falling during STORE: err asserts the next cycle. No SUB/COPY/ADD ops are issued.

## Structure
- Package `sample_ctrl_pkg` holds:
  - the opcode typedef/enum,
  - the register-index constants (ACC=0, OLD=4, NEW=5),
  - the FSM state enum (4-bit encoding).
- Single module: `always_ff` state register plus `always_comb` next-state/output decode. No sub-module.

## Test plan
- Reset: assert `n_reset`=0 mid-SH2 → all outputs 0 asynchronously. After release, FSM is in IDLE; `dr`=0 holds modwait=0.
- Single sample: `dr`=1 for 2 cycles from IDLE → cnt_up one pulse. op sequence is LOAD, SUB, COPY×4, ADD with the exact src/dest values above. modwait high 7 cycles. err=0, clear=0.
- Overflow: force `overflow`=1 in SUB_OLD → next state EIDLE, err=1, no COPY ops. Then `dr`=1 → err clears and the sequence restarts with STORE.
- Protocol error: `dr`=1 in IDLE then 0 in STORE → EIDLE, err=1 one cycle after STORE.
- Block end: pair with the 10-bit sample counter. Feed 1000 samples → `clear` pulses exactly once, the cycle after the 1000th ADD_NEW. Counter returns to 0, `one_k_samples` drops.
- Simultaneous events: `overflow` and `one_k_samples` both high in ADD_NEW → EIDLE, no `clear`. The next clean sample issues `clear`.
